mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Parametrised multicycle MIPS control unit: main-decoder FSM, ALU decoder and PC-enable logic in one block.
- Drives the multicycle datapath mux selects and write strobes from IR opcode/funct and the ALU zero flag.
- Adds features the base controller lacks: a variable-latency memory handshake, optional bne and immediate-logic instructions, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- MEM_HANDSHAKE, 1, 1: memory accesses stall until mem_ready=1; 0: mem_ready is ignored and treated as 1.
- SUPPORT_BNE, 1, enables decoding of bne (000101).
- SUPPORT_IMM_LOGIC, 1, enables decoding of andi (001100), ori (001101) and slti (001010).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- op  in  6  instr[31:26] from IR.
- funct  in  6  instr[5:0] from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- iord, irwrite, memwrite, memread, memtoreg, regwrite, regdst, alusrca, pcen, zeroext  out  1 each  datapath controls; zeroext selects zero-extension of the immediate for andi/ori.
- alusrcb, pcsrc  out  2 each  ALU B mux select; PC source (00 ALU, 01 ALUOut, 10 jump).
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0 at a clock edge): state <= FETCH, instret <= 0.
- While reset=0, every strobe output is forced to 0: irwrite, memwrite, memread, regwrite, pcen, illegal.
- Reset mid-instruction abandons the instruction; no write strobe follows.
- All outputs are combinational from the state, op, funct, zero and mem_ready.
- States and outputs (unlisted outputs are 0):
  - FETCH: memread=1, alusrcb=01, alucontrol=add. irwrite and pcen are 1 only when mem_ready. Go to DECODE on mem_ready, otherwise hold.
  - DECODE: alusrcb=11 (branch target precomputed). Next state by op:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq, or bne when SUPPORT_BNE=1 -> BRANCH
    - addi, or andi/ori/slti when SUPPORT_IMM_LOGIC=1 -> IMMEX
    - j -> JUMP
    - any other op -> illegal=1 this cycle, then FETCH.
  - MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord=1, memread=1. Hold until mem_ready, then MEMWB.
  - MEMWB: memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR: iord=1, memwrite=1. Hold until mem_ready, then FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct -> ALUWB.
    - funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
    - Any other funct: illegal=1 this cycle, next state FETCH, no regwrite.
  - ALUWB: regdst=1, regwrite=1 -> FETCH.
  - BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero for beq, ~zero for bne -> FETCH.
  - IMMEX: alusrca=1, alusrcb=10. addi add; andi and; ori or; slti slt. zeroext=1 for andi/ori -> IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP: pcsrc=10, pcen=1 -> FETCH.
- Latency in cycles with mem_ready held at 1:
  - lw 5; sw, R-type and imm 4; beq/bne and j 3.
  - Each extra cycle with mem_ready=0 adds one cycle.
- memwrite is asserted in every stalled MEMWR cycle. Memory must take only the mem_ready cycle as the write.
- mem_ready in a non-memory state is ignored.
- instret: +1 at the edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, IMMWB or JUMP.
  - Wraps modulo 2^CNT_W.
  - Illegal instructions are not counted.

Decomposition:
- Package mc_pkg holds:
  - the state enum (typedef statetype_t);
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J;
  - funct codes;
  - alucontrol codes.
- One sub-module, mc_aludec: combinational; aluop plus op plus funct in, alucontrol and funct_illegal out.

Test Plan:
- Hold reset=0 for 3 cycles with mem_ready=1 -> all strobes 0. Release -> FETCH, memread=1, instret=0.
- lw (op 100011), mem_ready=1 -> 5 cycles, regwrite=1 with memtoreg=1 in cycle 5, instret=1. Repeat with mem_ready=0 for 2 cycles in MEMRD -> 7 cycles, memread held.
- beq with zero=1 -> pcen=1, pcsrc=01 in cycle 3. bne with zero=1 -> pcen=0. Rebuilt with SUPPORT_BNE=0: op 000101 -> illegal pulse in DECODE, instret unchanged.
- R-type funct 101010 -> alucontrol=111 in EXECUTE. funct 000000 -> illegal=1, no regwrite.
- ori -> zeroext=1, alucontrol=001, regwrite=1 with regdst=0.
- CNT_W=4: retire 17 j instructions -> instret=1 (wrap). Pull reset=0 during MEMWR -> memwrite=0 that cycle, FETCH next.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, funct and ALU codes for the multicycle control unit
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop tells the ALU decoder where the operation comes from
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU decoder: aluop/op/funct to alucontrol, flags unknown R-type funct
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_funct_illegal
);

  always_comb begin
    o_alucontrol    = ALU_ADD;
    o_funct_illegal = 1'b0;
    case (i_aluop)
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_funct_illegal = 1'b1;
        endcase
      end
      ALUOP_IMM: begin
        case (i_op)
          OP_ANDI: o_alucontrol = ALU_AND;
          OP_ORI:  o_alucontrol = ALU_OR;
          OP_SLTI: o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS control unit with memory handshake and retire counter
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE     = 1'b1,
  parameter bit SUPPORT_BNE       = 1'b1,
  parameter bit SUPPORT_IMM_LOGIC = 1'b1,
  parameter int CNT_W             = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [5:0]       i_op,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_iord,
  output logic             o_irwrite,
  output logic             o_memwrite,
  output logic             o_memread,
  output logic             o_memtoreg,
  output logic             o_regwrite,
  output logic             o_regdst,
  output logic             o_alusrca,
  output logic             o_pcen,
  output logic             o_zeroext,
  output logic [1:0]       o_alusrcb,
  output logic [1:0]       o_pcsrc,
  output logic [2:0]       o_alucontrol,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instret
);

  statetype_t       r_state;
  statetype_t       w_next;
  logic [CNT_W-1:0] r_instret;
  logic [1:0]       w_aluop;
  logic             w_funct_illegal;
  logic             w_mem_ready;
  logic             w_retire;

  assign w_mem_ready = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
  assign o_instret   = r_instret;

  // aluop depends on state only, keeping funct_illegal out of a feedback path
  assign w_aluop = (r_state == S_EXECUTE) ? ALUOP_FUNCT :
                   (r_state == S_BRANCH)  ? ALUOP_SUB   :
                   (r_state == S_IMMEX)   ? ALUOP_IMM   : ALUOP_ADD;

  mc_aludec u_aludec (
    .i_aluop         (w_aluop),
    .i_op            (i_op),
    .i_funct         (i_funct),
    .o_alucontrol    (o_alucontrol),
    .o_funct_illegal (w_funct_illegal)
  );

  always_comb begin
    {o_iord, o_irwrite, o_memwrite, o_memread, o_memtoreg} = 5'b0;
    {o_regwrite, o_regdst, o_alusrca, o_pcen, o_zeroext}   = 5'b0;
    o_alusrcb = 2'b00;
    o_pcsrc   = 2'b00;
    o_illegal = 1'b0;
    w_retire  = 1'b0;
    w_next    = r_state;
    case (r_state)
      S_FETCH: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        if (w_mem_ready) begin
          o_irwrite = 1'b1;
          o_pcen    = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alusrcb = 2'b11;
        w_next    = S_FETCH;
        case (i_op)
          OP_LW, OP_SW:              w_next = S_MEMADR;
          OP_RTYPE:                  w_next = S_EXECUTE;
          OP_BEQ:                    w_next = S_BRANCH;
          OP_ADDI:                   w_next = S_IMMEX;
          OP_J:                      w_next = S_JUMP;
          OP_BNE:                    if (SUPPORT_BNE) w_next = S_BRANCH; else o_illegal = 1'b1;
          OP_ANDI, OP_ORI, OP_SLTI:  if (SUPPORT_IMM_LOGIC) w_next = S_IMMEX; else o_illegal = 1'b1;
          default:                   o_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        w_next    = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        o_iord    = 1'b1;
        o_memread = 1'b1;
        if (w_mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
        if (w_mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXECUTE: begin
        o_alusrca = 1'b1;
        o_illegal = w_funct_illegal;
        w_next    = w_funct_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        o_alusrca = 1'b1;
        o_pcsrc   = 2'b01;
        o_pcen    = (i_op == OP_BNE) ? ~i_zero : i_zero;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_IMMEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_zeroext = (i_op == OP_ANDI) || (i_op == OP_ORI);
        w_next    = S_IMMWB;
      end
      S_IMMWB: begin
        o_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        o_pcsrc  = 2'b10;
        o_pcen   = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // while reset is held no strobe may reach the datapath or memory
    if (!i_reset) begin
      {o_irwrite, o_memwrite, o_memread, o_regwrite, o_pcen, o_illegal} = 6'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - per-cycle scoreboard bench for mc_control_fsm (default and reduced builds)
module tb_mc_control_fsm;

  localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_ANDI = 6'b001100, T_ORI = 6'b001101, T_SLTI = 6'b001010, T_J = 6'b000010;
  localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000, A_OR = 3'b001, A_SLT = 3'b111;

  // single-bit control positions: {iord,irwrite,memwrite,memread,memtoreg,regwrite,regdst,alusrca,pcen,zeroext}
  localparam logic [9:0] B_IORD = 10'h200, B_IRW = 10'h100, B_MW = 10'h080, B_MR = 10'h040;
  localparam logic [9:0] B_M2R = 10'h020, B_RW = 10'h010, B_RD = 10'h008, B_ASA = 10'h004;
  localparam logic [9:0] B_PCEN = 10'h002, B_ZX = 10'h001, B_NONE = 10'h000;
  localparam logic [17:0] M_ALL = 18'h3FFFF, M_DC = 18'h3FFF1, M_STR = 18'h1D201;

  logic       clk, rst1, rst2, zero, mem_ready;
  logic [5:0] op, funct;
  logic [1:0] iord, irwrite, memwrite, memread, memtoreg, regwrite, regdst, alusrca, pcen, zeroext, illegal;
  logic [1:0] alusrcb [2];
  logic [1:0] pcsrc [2];
  logic [2:0] alucontrol [2];
  logic [31:0] instret1;
  logic [3:0]  instret2;

  typedef struct {
    string       tag;
    logic [17:0] exp;
    logic [17:0] msk;
    int unsigned ret;
  } sb_t;
  sb_t sb_q[$];

  int          n_checks, n_errors, sel;
  int unsigned exp_ret;

  mc_control_fsm dut1 (
    .i_clk(clk), .i_reset(rst1), .i_op(op), .i_funct(funct), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_iord(iord[0]), .o_irwrite(irwrite[0]), .o_memwrite(memwrite[0]), .o_memread(memread[0]),
    .o_memtoreg(memtoreg[0]), .o_regwrite(regwrite[0]), .o_regdst(regdst[0]), .o_alusrca(alusrca[0]),
    .o_pcen(pcen[0]), .o_zeroext(zeroext[0]), .o_alusrcb(alusrcb[0]), .o_pcsrc(pcsrc[0]),
    .o_alucontrol(alucontrol[0]), .o_illegal(illegal[0]), .o_instret(instret1)
  );

  mc_control_fsm #(.MEM_HANDSHAKE(1'b0), .SUPPORT_BNE(1'b0), .SUPPORT_IMM_LOGIC(1'b1), .CNT_W(4)) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_op(op), .i_funct(funct), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_iord(iord[1]), .o_irwrite(irwrite[1]), .o_memwrite(memwrite[1]), .o_memread(memread[1]),
    .o_memtoreg(memtoreg[1]), .o_regwrite(regwrite[1]), .o_regdst(regdst[1]), .o_alusrca(alusrca[1]),
    .o_pcen(pcen[1]), .o_zeroext(zeroext[1]), .o_alusrcb(alusrcb[1]), .o_pcsrc(pcsrc[1]),
    .o_alucontrol(alucontrol[1]), .o_illegal(illegal[1]), .o_instret(instret2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] obs(input int k);
    return {iord[k], irwrite[k], memwrite[k], memread[k], memtoreg[k], regwrite[k], regdst[k],
            alusrca[k], pcen[k], zeroext[k], alusrcb[k], pcsrc[k], alucontrol[k], illegal[k]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // expectation is queued as the cycle's inputs are applied and consumed mid-cycle
  task automatic cyc(input string tag, input logic [9:0] s, input logic [1:0] asb, input logic [1:0] pcs,
                     input logic [2:0] alu, input logic ill, input logic [17:0] msk);
    sb_t e;
    e.tag = tag;
    e.exp = {s, asb, pcs, alu, ill};
    e.msk = msk;
    e.ret = exp_ret;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.tag, 32'(obs(sel) & e.msk), 32'(e.exp & e.msk));
    if (sel == 1) check({e.tag, ".instret"}, {28'd0, instret2}, e.ret & 32'hF);
    else          check({e.tag, ".instret"}, instret1, e.ret);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".FETCH"}, B_MR | B_IRW | B_PCEN, 2'b01, 2'b00, A_ADD, 1'b0, M_ALL);
  endtask

  task automatic decode(input string tag, input logic ill);
    cyc({tag, ".DECODE"}, B_NONE, 2'b11, 2'b00, A_ADD, ill, M_DC);
  endtask

  task automatic memadr(input string tag);
    cyc({tag, ".MEMADR"}, B_ASA, 2'b10, 2'b00, A_ADD, 1'b0, M_ALL);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; sel = 0; exp_ret = 0;
    rst1 = 1'b0; rst2 = 1'b0; zero = 1'b0; mem_ready = 1'b1; op = T_LW; funct = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) cyc("reset", B_NONE, 2'b00, 2'b00, A_AND, 1'b0, M_STR);
    rst1 = 1'b1;

    op = T_LW;
    fetch("lw"); decode("lw", 1'b0); memadr("lw");
    cyc("lw.MEMRD", B_IORD | B_MR, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    cyc("lw.MEMWB", B_M2R | B_RW, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    exp_ret++;

    mem_ready = 1'b0;
    cyc("lw2.FETCH_stall", B_MR, 2'b01, 2'b00, A_ADD, 1'b0, M_ALL);
    mem_ready = 1'b1; fetch("lw2");
    mem_ready = 1'b0; decode("lw2", 1'b0); memadr("lw2");
    repeat (2) cyc("lw2.MEMRD_stall", B_IORD | B_MR, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    mem_ready = 1'b1;
    cyc("lw2.MEMRD", B_IORD | B_MR, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    cyc("lw2.MEMWB", B_M2R | B_RW, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    exp_ret++;

    op = T_SW;
    fetch("sw"); decode("sw", 1'b0); memadr("sw");
    mem_ready = 1'b0;
    repeat (2) cyc("sw.MEMWR_stall", B_IORD | B_MW, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    mem_ready = 1'b1;
    cyc("sw.MEMWR", B_IORD | B_MW, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    exp_ret++;

    for (int i = 0; i < 4; i++) begin
      op   = (i < 2) ? T_BEQ : T_BNE;
      zero = (i % 2 == 0);
      fetch("br"); decode("br", 1'b0);
      cyc("br.BRANCH", B_ASA | (((op == T_BEQ) == zero) ? B_PCEN : B_NONE), 2'b00, 2'b01, A_SUB, 1'b0, M_ALL);
      exp_ret++;
    end

    op = T_RTYPE;
    for (int i = 0; i < 5; i++) begin
      logic [5:0] fv [5];
      logic [2:0] av [5];
      fv = '{6'b101010, 6'b100010, 6'b100000, 6'b100100, 6'b100101};
      av = '{A_SLT, A_SUB, A_ADD, A_AND, A_OR};
      funct = fv[i];
      fetch("rtype"); decode("rtype", 1'b0);
      cyc("rtype.EXECUTE", B_ASA, 2'b00, 2'b00, av[i], 1'b0, M_ALL);
      cyc("rtype.ALUWB", B_RD | B_RW, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
      exp_ret++;
    end
    funct = 6'b000000;
    fetch("rbad"); decode("rbad", 1'b0);
    cyc("rbad.EXECUTE", B_ASA, 2'b00, 2'b00, A_ADD, 1'b1, M_DC);

    for (int i = 0; i < 4; i++) begin
      logic [5:0] ov [4];
      logic [2:0] av [4];
      ov = '{T_ORI, T_ANDI, T_SLTI, T_ADDI};
      av = '{A_OR, A_AND, A_SLT, A_ADD};
      op = ov[i];
      fetch("imm"); decode("imm", 1'b0);
      cyc("imm.IMMEX", B_ASA | ((i < 2) ? B_ZX : B_NONE), 2'b10, 2'b00, av[i], 1'b0, M_ALL);
      cyc("imm.IMMWB", B_RW, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
      exp_ret++;
    end

    op = T_J;
    fetch("j"); decode("j", 1'b0);
    cyc("j.JUMP", B_PCEN, 2'b00, 2'b10, A_ADD, 1'b0, M_DC);
    exp_ret++;

    op = 6'b111111;
    fetch("badop"); decode("badop", 1'b1);

    op = T_SW;
    fetch("swrst"); decode("swrst", 1'b0); memadr("swrst");
    mem_ready = 1'b0;
    cyc("swrst.MEMWR_stall", B_IORD | B_MW, 2'b00, 2'b00, A_ADD, 1'b0, M_DC);
    rst1 = 1'b0;
    cyc("swrst.MEMWR_reset", B_NONE, 2'b00, 2'b00, A_ADD, 1'b0, M_STR);
    exp_ret = 0;
    rst1 = 1'b1; mem_ready = 1'b1;
    fetch("after_reset");

    rst1 = 1'b0; sel = 1; exp_ret = 0;
    rst2 = 1'b1; mem_ready = 1'b0;
    op = T_BNE;
    fetch("nobne"); decode("nobne", 1'b1);
    op = T_J;
    for (int i = 0; i < 17; i++) begin
      fetch("j4"); decode("j4", 1'b0);
      cyc("j4.JUMP", B_PCEN, 2'b00, 2'b10, A_ADD, 1'b0, M_DC);
      exp_ret++;
    end
    fetch("j4.wrap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
